uart_rx: RTL and testbench

8N1 UART receiver, the receive counterpart of the board's 115200-baud transmitter. It is clocked from CLK_50 and takes the asynchronous RxD pin. It uses a 16x oversampling phase-accumulator tick, a synchronizer and mid-bit sampling, and delivers bytes through a ready/ack handshake with framing-error and overrun flags. It sits between the RxD pin and the consumer logic (LEDs, HEX display, command decoder).

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x phase-accumulator oversampling, 2-FF synchronizer, mid-bit sampling,
// ready/ack handshake with overrun and framing-error flags. Optional RX_MAJORITY_EN: 2-of-3 vote per bit.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int ACC_WIDTH = 16,
  parameter int OS_INC    = ((BAUD*16 << (ACC_WIDTH-7)) + (CLK_FREQ>>8)) / (CLK_FREQ>>7)
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic       RxD,
  input  logic       RxD_ack,
  output logic [7:0] RxD_data,
  output logic       RxD_ready,
  output logic       RxD_overrun,
  output logic       RxD_frame_err,
  output logic       RxD_busy,
  output logic       OsTick
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  localparam logic [ACC_WIDTH:0] INC = (ACC_WIDTH+1)'(OS_INC);

  state_t             state;
  logic [ACC_WIDTH:0] acc;
  logic               rx_meta;
  logic               rxs;
  logic [3:0]         os_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               bit_val;

  // Carry out of the accumulator is the oversample tick; it free-runs regardless of line activity.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) acc <= '0;
    else          acc <= {1'b0, acc[ACC_WIDTH-1:0]} + INC;
  end
  assign OsTick = acc[ACC_WIDTH];

  // NOTE: the synchronizer resets to 1 (idle line) so release from reset never looks like a start bit.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) {rxs, rx_meta} <= 2'b11;
    else          {rxs, rx_meta} <= {rx_meta, RxD};
  end

`ifdef RX_MAJORITY_EN
  localparam logic [3:0] START_PT = 4'd8;
  logic [1:0] hist;

  // The two samples preceding the decision tick; the third vote is the current rxs.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N)    hist <= 2'b11;
    else if (OsTick) hist <= {hist[0], rxs};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  localparam logic [3:0] START_PT = 4'd7;
  assign bit_val = rxs;
`endif

  // After the start-bit re-alignment, os_cnt==15 marks the mid point of every following bit.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      os_cnt        <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      RxD_data      <= '0;
      RxD_ready     <= 1'b0;
      RxD_overrun   <= 1'b0;
      RxD_frame_err <= 1'b0;
      RxD_busy      <= 1'b0;
    end else begin
      RxD_frame_err <= 1'b0;
      // Later assignments in the FSM override this clear, so a completing byte wins over ack.
      if (RxD_ack && RxD_ready) begin
        RxD_ready   <= 1'b0;
        RxD_overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            os_cnt   <= '0;
            state    <= START;
            RxD_busy <= 1'b1;
          end
        end
        START: begin
          if (OsTick) begin
            if (os_cnt == START_PT) begin
              os_cnt <= '0;
              if (bit_val) begin
                state    <= IDLE;
                RxD_busy <= 1'b0;
              end else begin
                bit_idx <= '0;
                state   <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (OsTick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              shreg   <= {bit_val, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end
          end
        end
        STOP: begin
          if (OsTick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              if (bit_val) begin
                RxD_data  <= shreg;
                RxD_ready <= 1'b1;
                if (RxD_ready && !RxD_ack) RxD_overrun <= 1'b1;
                state     <= IDLE;
                RxD_busy  <= 1'b0;
              end else begin
                RxD_frame_err <= 1'b1;
                state         <= WAIT_HIGH;
              end
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state    <= IDLE;
            RxD_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          RxD_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 115200-baud frames driven at 434 clocks per bit on a 50 MHz clock.
module tb_uart_rx;

  localparam int BIT = 434;

  logic       CLK_50;
  logic       RESET_N;
  logic       RxD;
  logic       RxD_ack;
  logic [7:0] RxD_data;
  logic       RxD_ready;
  logic       RxD_overrun;
  logic       RxD_frame_err;
  logic       RxD_busy;
  logic       OsTick;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc       = 0;
  int rise_cyc  = 0;
  int rise_cnt  = 0;
  int fe_cnt    = 0;
  int tick_cnt  = 0;
  int start_cyc = 0;
  logic ready_q = 1'b0;
  logic [7:0] got[$];

  uart_rx dut (
    .CLK_50       (CLK_50),
    .RESET_N      (RESET_N),
    .RxD          (RxD),
    .RxD_ack      (RxD_ack),
    .RxD_data     (RxD_data),
    .RxD_ready    (RxD_ready),
    .RxD_overrun  (RxD_overrun),
    .RxD_frame_err(RxD_frame_err),
    .RxD_busy     (RxD_busy),
    .OsTick       (OsTick)
  );

  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  // Passive monitors: cycle count, ready rising edges, frame-error cycles, oversample ticks.
  always @(posedge CLK_50) begin
    cyc     <= cyc + 1;
    ready_q <= RxD_ready;
    if (RxD_ready && !ready_q) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (RxD_frame_err) fe_cnt <= fe_cnt + 1;
    if (OsTick) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  // Drives one frame; during the stop bit optionally acks the byte one clock after ready is seen.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit auto_ack);
    bit acked;
    acked = 0;
    @(negedge CLK_50);
    start_cyc = cyc;
    RxD = 1'b0;
    wait_clks(BIT - 1);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      wait_clks(BIT);
    end
    RxD = stop;
    for (int k = 0; k < BIT; k++) begin
      RxD_ack = 1'b0;
      if (auto_ack && RxD_ready && !acked) begin
        got.push_back(RxD_data);
        RxD_ack = 1'b1;
        acked = 1;
      end
      @(negedge CLK_50);
    end
    RxD_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    RxD_ack = 1'b1;
    @(negedge CLK_50);
    RxD_ack = 1'b0;
    @(negedge CLK_50);
  endtask

  initial begin
    int t0, lat, fe0, r0;

    RESET_N = 1'b0;
    RxD     = 1'b1;
    RxD_ack = 1'b0;
    wait_clks(5);
    check("rst_data",    RxD_data,      8'h00);
    check("rst_ready",   RxD_ready,     1'b0);
    check("rst_overrun", RxD_overrun,   1'b0);
    check("rst_ferr",    RxD_frame_err, 1'b0);
    check("rst_busy",    RxD_busy,      1'b0);
    check("rst_tick",    OsTick,        1'b0);
    RESET_N = 1'b1;

    // 10000 clocks x 2416/65536 = 368.65 ticks
    t0 = tick_cnt;
    wait_clks(10000);
    check("tick_rate", ((tick_cnt - t0) >= 368 && (tick_cnt - t0) <= 369), 1'b1);
    check("idle_busy", RxD_busy, 1'b0);

    fe0 = fe_cnt;
    send_frame(8'h35, 1'b1, 0);
    check("b35_data",  RxD_data,  8'h35);
    check("b35_ready", RxD_ready, 1'b1);
    lat = rise_cyc - start_cyc;
    check("b35_latency", (lat >= 4050 && lat <= 4200), 1'b1);
    check("b35_noferr", fe_cnt - fe0, 0);
    pulse_ack();
    check("ack_clears_ready", RxD_ready, 1'b0);

    got.delete();
    send_frame(8'h75, 1'b1, 1);
    send_frame(8'h4C, 1'b1, 1);
    send_frame(8'h61, 1'b1, 1);
    send_frame(8'h62, 1'b1, 1);
    check("ulab_count", got.size(), 4);
    if (got.size() == 4) begin
      check("ulab_0", got[0], 8'h75);
      check("ulab_1", got[1], 8'h4C);
      check("ulab_2", got[2], 8'h61);
      check("ulab_3", got[3], 8'h62);
    end
    check("ulab_overrun", RxD_overrun, 1'b0);
    check("ulab_ready",   RxD_ready,   1'b0);

    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h5A, 1'b1, 0);
    check("ovr_data",    RxD_data,    8'h5A);
    check("ovr_ready",   RxD_ready,   1'b1);
    check("ovr_overrun", RxD_overrun, 1'b1);
    pulse_ack();
    check("ovr_ack_ready",   RxD_ready,   1'b0);
    check("ovr_ack_overrun", RxD_overrun, 1'b0);

    // Ack with nothing pending must not disturb the next byte.
    pulse_ack();

    // Short low glitch on an idle line.
    fe0 = fe_cnt;
    r0  = rise_cnt;
    RxD = 1'b0;
    wait_clks(50);
    check("glitch_busy", RxD_busy, 1'b1);
    wait_clks(50);
    RxD = 1'b1;
    wait_clks(500);
    check("glitch_idle",   RxD_busy,       1'b0);
    check("glitch_noferr", fe_cnt - fe0,   0);
    check("glitch_noready", rise_cnt - r0, 0);

    // Bad stop bit followed by a held-low break.
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 0);
    wait_clks(3000);
    check("brk_ferr_once", fe_cnt - fe0, 1);
    check("brk_busy",      RxD_busy,     1'b1);
    check("brk_ready",     RxD_ready,    1'b0);
    check("brk_data_kept", RxD_data,     8'h5A);
    RxD = 1'b1;
    wait_clks(20);
    check("brk_release", RxD_busy, 1'b0);
    send_frame(8'h42, 1'b1, 0);
    check("b42_data",  RxD_data,  8'h42);
    check("b42_ready", RxD_ready, 1'b1);

    // Reset in the middle of data bit 4 of 8'hFF.
    fe0 = fe_cnt;
    @(negedge CLK_50);
    RxD = 1'b0;
    wait_clks(BIT);
    RxD = 1'b1;
    wait_clks(4 * BIT + BIT / 2);
    check("mid_busy", RxD_busy, 1'b1);
    RESET_N = 1'b0;
    #1;
    check("mrst_data",    RxD_data,    8'h00);
    check("mrst_ready",   RxD_ready,   1'b0);
    check("mrst_busy",    RxD_busy,    1'b0);
    check("mrst_overrun", RxD_overrun, 1'b0);
    wait_clks(4);
    RESET_N = 1'b1;
    wait_clks(4 * BIT);
    r0 = rise_cnt;
    send_frame(8'h11, 1'b1, 0);
    check("b11_data",   RxD_data,     8'h11);
    check("b11_ready",  RxD_ready,    1'b1);
    check("b11_once",   rise_cnt - r0, 1);
    check("b11_noferr", fe_cnt - fe0, 0);
    pulse_ack();

`ifdef RX_MAJORITY_EN
    // 8'h00 with a one-clock high spike mid data bit 3 (sync delay of 2 places it on a sample).
    fe0 = fe_cnt;
    @(negedge CLK_50);
    RxD = 1'b0;
    wait_clks(BIT - 1);
    wait_clks(3 * BIT);
    wait_clks(BIT / 2 - 2);
    RxD = 1'b1;
    wait_clks(1);
    RxD = 1'b0;
    wait_clks(BIT - BIT / 2 + 1);
    wait_clks(4 * BIT);
    RxD = 1'b1;
    wait_clks(BIT);
    check("maj_data",   RxD_data,     8'h00);
    check("maj_ready",  RxD_ready,    1'b1);
    check("maj_noferr", fe_cnt - fe0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
